// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU fetch/data ports and the single memory port seen by mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_LEN  = 32
);
  logic                 i_req;
  logic [ADDR_SIZE-1:0] i_addr;
  logic                 i_abort;
  logic                 i_done;
  logic [WORD_LEN-1:0]  i_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [ADDR_SIZE-1:0] d_addr;
  logic [WORD_LEN-1:0]  d_wdata;
  logic [2:0]           d_size;
  logic                 d_done;
  logic [WORD_LEN-1:0]  d_rdata;

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_LEN-1:0]  mem_wdata;
  logic [2:0]           mem_size;
  logic                 mem_ready;
  logic [WORD_LEN-1:0]  mem_rdata;

  modport slave (
    input  i_req, i_addr, i_abort,
    output i_done, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_size,
    output d_done, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_ready, mem_rdata
  );

  modport master (
    output i_req, i_addr, i_abort,
    input  i_done, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_size,
    input  d_done, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time.
// state  | meaning
// IDLE   | no transaction; arbitrate pending requests
// BUSY_I | fetch owns the memory port, waiting for mem_ready
// BUSY_D | data access owns the memory port, waiting for mem_ready
// RESP   | one-cycle done pulse to the owner
module mem_port_arbiter #(
  parameter int ADDR_SIZE   = 32,
  parameter int WORD_LEN    = 32,
  parameter int DATA_STREAK = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} stateT;

  stateT                state;
  stateT                nextState;
  logic [3:0]           streak;
  logic                 ownerData;
  logic                 iDiscard;
  logic                 weQ;
  logic [2:0]           sizeQ;
  logic [ADDR_SIZE-1:0] addrQ;
  logic [WORD_LEN-1:0]  wdataQ;
  logic [WORD_LEN-1:0]  iRdataQ;
  logic [WORD_LEN-1:0]  dRdataQ;
  logic                 fetchPending;
  logic                 grantI;
  logic                 grantD;

  assign fetchPending = bus.i_req && !bus.i_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    case (state)
      IDLE: begin
        // Data has priority until it has won STREAK_MAX times in a row over a waiting fetch.
        if (bus.d_req && !(fetchPending && streak == STREAK_MAX)) begin
          grantD    = 1'b1;
          nextState = BUSY_D;
        end else if (fetchPending) begin
          grantI    = 1'b1;
          nextState = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: if (bus.mem_ready) nextState = RESP;
      RESP:           nextState = IDLE;
      default:        nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak    <= '0;
      ownerData <= 1'b0;
      iDiscard  <= 1'b0;
      weQ       <= 1'b0;
      sizeQ     <= '0;
      addrQ     <= '0;
      wdataQ    <= '0;
      iRdataQ   <= '0;
      dRdataQ   <= '0;
    end else begin
      if (grantD) begin
        ownerData <= 1'b1;
        weQ       <= bus.d_we;
        sizeQ     <= bus.d_size;
        addrQ     <= bus.d_addr;
        wdataQ    <= bus.d_wdata;
        if (!fetchPending)           streak <= '0;
        else if (streak < STREAK_MAX) streak <= streak + 4'd1;
      end
      if (grantI) begin
        ownerData <= 1'b0;
        iDiscard  <= 1'b0;
        weQ       <= 1'b0;
        sizeQ     <= 3'b010;
        addrQ     <= bus.i_addr;
        wdataQ    <= '0;
        streak    <= '0;
      end
      if (state == BUSY_I) begin
        if (bus.i_abort) iDiscard <= 1'b1;
        if (bus.mem_ready && !bus.i_abort && !iDiscard) iRdataQ <= bus.mem_rdata;
      end
      if (state == BUSY_D && bus.mem_ready) dRdataQ <= weQ ? '0 : bus.mem_rdata;
    end
  end

  assign bus.mem_req   = (state == BUSY_I) || (state == BUSY_D);
  assign bus.mem_we    = (state == BUSY_D) && weQ;
  assign bus.mem_addr  = addrQ;
  assign bus.mem_wdata = wdataQ;
  assign bus.mem_size  = sizeQ;
  assign bus.i_done    = (state == RESP) && !ownerData && !iDiscard;
  assign bus.d_done    = (state == RESP) && ownerData;
  assign bus.i_rdata   = iRdataQ;
  assign bus.d_rdata   = dRdataQ;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatched;

  mem_port_arbiter_if #(.ADDR_SIZE(32), .WORD_LEN(32)) bus ();

  mem_port_arbiter #(.ADDR_SIZE(32), .WORD_LEN(32), .DATA_STREAK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic waitGrant(output bit ok);
    int w;
    w = 0;
    while (!bus.mem_req && w < 6) begin
      cyc();
      w++;
    end
    ok = bus.mem_req;
  endtask

  initial begin
    string expOrder;
    string tag;
    bit    ok;
    logic [31:0] expAddr;

    nCompared   = 0;
    nMismatched = 0;
    expOrder    = "DDDDIDDDDI";
    rst         = 1'b1;
    bus.i_req = 0; bus.i_addr = '0; bus.i_abort = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_size = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;

    // reset state
    #12;
    checkVal("rst_mem_req", bus.mem_req, 0);
    checkVal("rst_mem_addr", bus.mem_addr, 0);
    checkVal("rst_d_done", bus.d_done, 0);
    checkVal("rst_i_rdata", bus.i_rdata, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // single load
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100; bus.d_size = 3'b010;
    cyc();
    checkVal("load_mem_req", bus.mem_req, 1);
    checkVal("load_mem_addr", bus.mem_addr, 32'h100);
    checkVal("load_mem_we", bus.mem_we, 0);
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    cyc();
    bus.mem_ready = 0; bus.d_req = 0;
    checkVal("load_d_done", bus.d_done, 1);
    checkVal("load_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    checkVal("load_mem_req_resp", bus.mem_req, 0);
    cyc();
    checkVal("load_done_once", bus.d_done, 0);
    checkVal("load_rdata_hold", bus.d_rdata, 32'hDEADBEEF);

    // store with a two-cycle memory
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678; bus.d_size = 3'b000;
    cyc();
    checkVal("st_mem_we", bus.mem_we, 1);
    checkVal("st_mem_wdata", bus.mem_wdata, 32'h12345678);
    checkVal("st_mem_size", bus.mem_size, 3'b000);
    cyc();
    checkVal("st_busy_hold", bus.mem_req, 1);
    checkVal("st_no_early_done", bus.d_done, 0);
    bus.mem_ready = 1; bus.mem_rdata = 32'hFFFF0000;
    cyc();
    bus.mem_ready = 0; bus.d_req = 0; bus.d_we = 0;
    checkVal("st_d_done", bus.d_done, 1);
    checkVal("st_d_rdata", bus.d_rdata, 0);
    checkVal("st_mem_we_resp", bus.mem_we, 0);
    cyc();

    // contention, single-cycle memory
    bus.i_req = 1; bus.i_addr = 32'h40;
    bus.d_req = 1; bus.d_addr = 32'h300; bus.d_size = 3'b010;
    bus.mem_ready = 1; bus.mem_rdata = 32'hA5A50001;
    for (int k = 0; k < 10; k++) begin
      waitGrant(ok);
      tag = $sformatf("grant_%0d", k);
      expAddr = (expOrder[k] == "I") ? 32'h40 : 32'h300;
      if (!ok) checkVal({tag, "_timeout"}, 0, 1);
      else     checkVal(tag, bus.mem_addr, expAddr);
      if (k == 9) begin
        bus.i_req = 0; bus.d_req = 0;
      end
      cyc();
    end
    checkVal("cont_i_done", bus.i_done, 1);
    bus.mem_ready = 0;
    cyc();
    checkVal("cont_i_rdata", bus.i_rdata, 32'hA5A50001);
    checkVal("cont_idle", bus.mem_req, 0);

    // fetch aborted while in flight
    bus.i_req = 1; bus.i_addr = 32'h40;
    cyc();
    checkVal("ab_mem_req", bus.mem_req, 1);
    checkVal("ab_mem_size", bus.mem_size, 3'b010);
    bus.i_abort = 1;
    cyc();
    bus.i_abort = 0; bus.i_req = 0;
    cyc();
    bus.mem_ready = 1; bus.mem_rdata = 32'h11112222;
    cyc();
    bus.mem_ready = 0;
    checkVal("ab_no_i_done", bus.i_done, 0);
    checkVal("ab_i_rdata_kept", bus.i_rdata, 32'hA5A50001);
    cyc();
    checkVal("ab_idle", bus.mem_req, 0);
    bus.d_req = 1; bus.d_addr = 32'h500;
    cyc();
    checkVal("ab_next_d_addr", bus.mem_addr, 32'h500);
    bus.mem_ready = 1; bus.mem_rdata = 32'h0BADF00D;
    cyc();
    bus.mem_ready = 0; bus.d_req = 0;
    checkVal("ab_next_d_done", bus.d_done, 1);
    checkVal("ab_next_d_rdata", bus.d_rdata, 32'h0BADF00D);
    cyc();

    // abort coinciding with mem_ready
    bus.i_req = 1; bus.i_addr = 32'h44;
    cyc();
    bus.i_abort = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h33334444;
    cyc();
    bus.i_abort = 0; bus.mem_ready = 0; bus.i_req = 0;
    checkVal("abrdy_no_i_done", bus.i_done, 0);
    checkVal("abrdy_i_rdata", bus.i_rdata, 32'hA5A50001);
    cyc();

    // abort in IDLE only blocks that cycle
    bus.i_req = 1; bus.i_addr = 32'h80; bus.i_abort = 1;
    cyc();
    checkVal("idleab_no_grant", bus.mem_req, 0);
    bus.i_abort = 0;
    cyc();
    checkVal("idleab_grant_addr", bus.mem_addr, 32'h80);
    checkVal("idleab_mem_req", bus.mem_req, 1);
    bus.mem_ready = 1; bus.mem_rdata = 32'h55667788;
    cyc();
    bus.mem_ready = 0; bus.i_req = 0;
    checkVal("idleab_i_done", bus.i_done, 1);
    checkVal("idleab_i_rdata", bus.i_rdata, 32'h55667788);
    cyc();

    // stray mem_ready in IDLE
    bus.mem_ready = 1; bus.mem_rdata = 32'h99999999;
    for (int k = 0; k < 2; k++) begin
      cyc();
      checkVal($sformatf("stray_i_done_%0d", k), bus.i_done, 0);
      checkVal($sformatf("stray_d_done_%0d", k), bus.d_done, 0);
      checkVal($sformatf("stray_mem_req_%0d", k), bus.mem_req, 0);
    end
    bus.mem_ready = 0;
    checkVal("stray_d_rdata", bus.d_rdata, 32'h0BADF00D);

    // asynchronous reset mid-BUSY_D
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h600;
    cyc();
    checkVal("ar_busy", bus.mem_req, 1);
    #2 rst = 1'b1;
    #1;
    checkVal("ar_mem_req_async", bus.mem_req, 0);
    checkVal("ar_mem_addr_async", bus.mem_addr, 0);
    checkVal("ar_d_rdata_async", bus.d_rdata, 0);
    #1 rst = 1'b0;
    bus.d_req = 0;
    bus.mem_ready = 1;
    cyc();
    checkVal("ar_no_d_done", bus.d_done, 0);
    checkVal("ar_idle", bus.mem_req, 0);
    bus.mem_ready = 0;
    cyc();
    checkVal("ar_no_d_done2", bus.d_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 32, width of all address ports.
REQ-002 Parameter WORD_LEN, default 32, width of all data ports.
REQ-003 Parameter DATA_STREAK, default 4, maximum consecutive data grants while a fetch waits; legal range 1..15.
REQ-004 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port i_req  input  1  instruction-fetch request; held with i_addr stable until i_done or i_abort.
REQ-007 Port i_addr  input  ADDR_SIZE  fetch address.
REQ-008 Port i_abort  input  1  fetch flush (branch taken); discards the pending or in-flight fetch.
REQ-009 Port i_done  output  1  one-cycle pulse; i_rdata valid.
REQ-010 Port i_rdata  output  WORD_LEN  fetched instruction word.
REQ-011 Port d_req  input  1  data request; held with d_we/d_addr/d_wdata/d_size stable until d_done.
REQ-012 Port d_we  input  1  1 = store, 0 = load.
REQ-013 Port d_addr  input  ADDR_SIZE  data address.
REQ-014 Port d_wdata  input  WORD_LEN  store data.
REQ-015 Port d_size  input  3  funct3 unit size, passed through unchanged.
REQ-016 Port d_done  output  1  one-cycle pulse; d_rdata valid for loads.
REQ-017 Port d_rdata  output  WORD_LEN  load data; 0 after a store.
REQ-018 Ports mem_req/mem_we  output  1/1, mem_addr  output  ADDR_SIZE, mem_wdata  output  WORD_LEN, mem_size  output  3: registered request to the single-ported memory.
REQ-019 Ports mem_ready  input  1, mem_rdata  input  WORD_LEN: completion strobe, read data valid in the same cycle.

Function
REQ-020 FSM states IDLE, BUSY_I, BUSY_D, RESP; arbiter SHALL serve exactly one transaction at a time.
REQ-021 IDLE: d_req only -> BUSY_D; i_req && !i_abort only -> BUSY_I; neither -> stay IDLE.
REQ-022 IDLE, both pending: data wins unless streak == DATA_STREAK, in which case fetch wins.
REQ-023 streak: 4-bit counter, +1 per data grant made while i_req && !i_abort; cleared on any fetch grant or when no fetch is waiting at a data grant; saturates at DATA_STREAK.
REQ-024 On a grant, request fields SHALL be latched; mem_req = 1 and latched fields SHALL drive mem_* throughout BUSY_x; in every other state mem_req = 0, mem_we = 0.
REQ-025 Fetch grant: mem_we = 0, mem_size = 3'b010 (word).
REQ-026 BUSY_x && mem_ready -> RESP, mem_rdata latched; mem_ready in IDLE or RESP SHALL be ignored.
REQ-027 RESP lasts exactly one cycle, pulses the owner's done, then -> IDLE; requests are not sampled in RESP.
REQ-028 Minimum latency: req sampled in IDLE cycle 0, mem_req cycle 1, mem_ready cycle 1, done cycle 2, next grant decided cycle 3.
REQ-029 i_abort in BUSY_I: the memory access SHALL complete, but i_done SHALL stay 0 in the following RESP.
REQ-030 i_abort in IDLE suppresses the fetch grant for that cycle only.
REQ-031 i_abort during a data transaction SHALL have no effect.
REQ-032 Simultaneous i_abort and mem_ready in BUSY_I: result discarded, no i_done.
REQ-033 i_rdata/d_rdata SHALL hold their value until the next done pulse for the same port.

Reset
REQ-034 While rst is high, state = IDLE, streak = 0, and all outputs are 0, applied immediately without waiting for clk.
REQ-035 Reset mid-transaction SHALL drop mem_req immediately and abandon the transaction with no done pulse.

Verification
REQ-036 Single load: d_req, d_we=0, d_addr=0x100, mem_ready at cycle 1 with mem_rdata=0xDEADBEEF -> d_done=1 and d_rdata=0xDEADBEEF at cycle 2, mem_req=0 at cycle 2.
REQ-037 Contention: i_req and d_req held continuously, DATA_STREAK=4, single-cycle memory -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-038 Abort: i_req at 0x40 granted, i_abort pulsed in BUSY_I, mem_ready two cycles later -> no i_done pulse, FSM back in IDLE, next d_req served normally.
REQ-039 Store: d_we=1, d_wdata=0x12345678, d_size=3'b000 -> mem_we=1, mem_wdata=0x12345678, mem_size=3'b000 during BUSY_D; d_done=1 with d_rdata=0.
REQ-040 Async reset: rst asserted mid-BUSY_D between clock edges -> mem_req=0 before the next edge; after release, no d_done pulse and state is IDLE.
REQ-041 Stray mem_ready in IDLE -> no done pulse and no state change.
